// File: rtl/wb_regfile.sv
// wb_regfile: write-back stage and architectural register file of the
// 5-stage MIPS pipeline.
//
// Purpose:
//   Selects the write-back value from the MEM/WB pipeline register, commits
//   it into a 32-entry register file, and serves the two ID-stage read ports.
//   A write in the current cycle is visible on a matching read port in the
//   same cycle (write-first bypass). A retired-write counter is provided for
//   debug visibility.
//
// Ports:
//   clk        pipeline clock, all state updates on the rising edge
//   rst        synchronous active-high reset (clears registers and counter)
//   reg_write  commit the write-back value this cycle
//   mem_to_reg select Mem_Data as the write-back value
//   write_pc_4 select PC1 (link value); takes priority over mem_to_reg
//   wReg       destination register address
//   ALU_Res    ALU result
//   Mem_Data   load data
//   PC1        PC+4 of the instruction
//   rReg1      read address A
//   rReg2      read address B
//   rData1     read data A (combinational)
//   rData2     read data B (combinational)
//   wb_data    selected write-back value (combinational, forwarded to EX)
//   wb_count   committed writes to non-zero registers since reset
module wb_regfile #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  reg_write,
    input  logic                  mem_to_reg,
    input  logic                  write_pc_4,
    input  logic [DEPTH_LOG2-1:0] wReg,
    input  logic [WIDTH-1:0]      ALU_Res,
    input  logic [WIDTH-1:0]      Mem_Data,
    input  logic [WIDTH-1:0]      PC1,
    input  logic [DEPTH_LOG2-1:0] rReg1,
    input  logic [DEPTH_LOG2-1:0] rReg2,
    output logic [WIDTH-1:0]      rData1,
    output logic [WIDTH-1:0]      rData2,
    output logic [WIDTH-1:0]      wb_data,
    output logic [WIDTH-1:0]      wb_count
);

    localparam int NUM_REGS = 2 ** DEPTH_LOG2;

    logic [WIDTH-1:0] regs [NUM_REGS];
    logic [WIDTH-1:0] wb_count_q;
    logic             commit;

    // Link value wins over load data, which wins over the ALU result.
    always_comb begin
        wb_data = ALU_Res;
        if (write_pc_4) begin
            wb_data = PC1;
        end else if (mem_to_reg) begin
            wb_data = Mem_Data;
        end
    end

    // Register 0 is never written, so a write to it is not a commit either.
    assign commit = reg_write && (wReg != '0);

    // Register array and retired-write counter. Reset wins over a commit
    // presented in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            regs       <= '{default: '0};
            wb_count_q <= '0;
        end else if (commit) begin
            regs[wReg] <= wb_data;
            wb_count_q <= wb_count_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    // Read ports: register 0 reads zero even while it is being targeted, and
    // an in-flight write to the addressed register is forwarded.
    always_comb begin
        rData1 = regs[rReg1];
        if (rReg1 == '0) begin
            rData1 = '0;
        end else if (reg_write && (wReg == rReg1)) begin
            rData1 = wb_data;
        end
    end

    always_comb begin
        rData2 = regs[rReg2];
        if (rReg2 == '0) begin
            rData2 = '0;
        end else if (reg_write && (wReg == rReg2)) begin
            rData2 = wb_data;
        end
    end

    assign wb_count = wb_count_q;

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: self-checking bench for wb_regfile.
//
// Purpose:
//   Drives directed and randomized MEM/WB and read-port traffic. For every
//   cycle the stimulus side computes the expected outputs from a plain array
//   model of the register file and pushes them into a queue; a separate
//   monitor pops one entry per cycle on the falling clock edge and compares.
//
// Ports: none (top-level bench).
module tb_wb_regfile;

    logic        clk;
    logic        rst;
    logic        reg_write;
    logic        mem_to_reg;
    logic        write_pc_4;
    logic [4:0]  wReg;
    logic [31:0] ALU_Res;
    logic [31:0] Mem_Data;
    logic [31:0] PC1;
    logic [4:0]  rReg1;
    logic [4:0]  rReg2;
    logic [31:0] rData1;
    logic [31:0] rData2;
    logic [31:0] wb_data;
    logic [31:0] wb_count;

    typedef struct {
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] wb;
        logic [31:0] cnt;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model_regs [32];
    logic [31:0] model_count;
    bit          deposit_max;
    int          total;
    int          bad;

    wb_regfile #(.WIDTH(32), .DEPTH_LOG2(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .reg_write  (reg_write),
        .mem_to_reg (mem_to_reg),
        .write_pc_4 (write_pc_4),
        .wReg       (wReg),
        .ALU_Res    (ALU_Res),
        .Mem_Data   (Mem_Data),
        .PC1        (PC1),
        .rReg1      (rReg1),
        .rReg2      (rReg2),
        .rData1     (rData1),
        .rData2     (rData2),
        .wb_data    (wb_data),
        .wb_count   (wb_count)
    );

    // 10 ns clock, rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model_wb();
        if (write_pc_4) return PC1;
        if (mem_to_reg) return Mem_Data;
        return ALU_Res;
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] addr);
        if (addr == 5'd0) return 32'd0;
        if (reg_write && wReg == addr) return model_wb();
        return model_regs[addr];
    endfunction

    // Apply what the inputs present at the edge just taken would do.
    task automatic model_edge();
        if (rst) begin
            for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
            model_count = 32'd0;
        end else if (reg_write && wReg != 5'd0) begin
            model_regs[wReg] = model_wb();
            model_count = model_count + 32'd1;
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus: settle the model for the previous edge, drive
    // new inputs, and queue the outputs they should produce this cycle.
    task automatic applyStimulus(input bit r, input bit rw, input bit m2r,
                                 input bit pc4, input logic [4:0] wr,
                                 input logic [31:0] alu, input logic [31:0] mem,
                                 input logic [31:0] pc, input logic [4:0] a,
                                 input logic [4:0] b);
        exp_t e;
        @(posedge clk);
        #2;
        model_edge();
        if (deposit_max) begin
            dut.wb_count_q = 32'hFFFF_FFFF;
            model_count    = 32'hFFFF_FFFF;
            deposit_max    = 1'b0;
        end
        rst        = r;
        reg_write  = rw;
        mem_to_reg = m2r;
        write_pc_4 = pc4;
        wReg       = wr;
        ALU_Res    = alu;
        Mem_Data   = mem;
        PC1        = pc;
        rReg1      = a;
        rReg2      = b;
        e.r1  = model_read(a);
        e.r2  = model_read(b);
        e.wb  = model_wb();
        e.cnt = model_count;
        exp_q.push_back(e);
    endtask

    task automatic idle_read(input logic [4:0] a, input logic [4:0] b);
        applyStimulus(0, 0, 0, 0, 5'd0, 32'd0, 32'd0, 32'd0, a, b);
    endtask

    // Monitor: one queued expectation per cycle, compared mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput("rData1", rData1, e.r1);
            checkOutput("rData2", rData2, e.r2);
            checkOutput("wb_data", wb_data, e.wb);
            checkOutput("wb_count", wb_count, e.cnt);
        end
    end

    initial begin
        total = 0;
        bad = 0;
        deposit_max = 1'b0;
        model_count = 32'd0;
        for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
        rst = 1'b1; reg_write = 1'b0; mem_to_reg = 1'b0; write_pc_4 = 1'b0;
        wReg = 5'd0; ALU_Res = 32'd0; Mem_Data = 32'd0; PC1 = 32'd0;
        rReg1 = 5'd0; rReg2 = 5'd0;

        // Reset, then r5 = 0x1234, then reset with a write to r6 pending.
        applyStimulus(1, 0, 0, 0, 5'd0, 32'd0, 32'd0, 32'd0, 5'd5, 5'd6);
        idle_read(5'd5, 5'd6);
        applyStimulus(0, 1, 0, 0, 5'd5, 32'h1234, 32'd0, 32'd0, 5'd5, 5'd0);
        idle_read(5'd5, 5'd6);
        applyStimulus(1, 1, 0, 0, 5'd6, 32'h7777, 32'd0, 32'd0, 5'd5, 5'd1);
        idle_read(5'd5, 5'd6);

        // Select priority, committed to r31, r8, r9.
        applyStimulus(0, 1, 1, 1, 5'd31, 32'hA, 32'hB, 32'hC, 5'd1, 5'd2);
        applyStimulus(0, 1, 1, 0, 5'd8, 32'hA, 32'hB, 32'hC, 5'd31, 5'd8);
        applyStimulus(0, 1, 0, 0, 5'd9, 32'hA, 32'hB, 32'hC, 5'd9, 5'd8);
        idle_read(5'd31, 5'd8);
        idle_read(5'd9, 5'd31);

        // Dual bypass on r7, then read back.
        applyStimulus(0, 1, 0, 0, 5'd7, 32'hDEADBEEF, 32'd0, 32'd0, 5'd7, 5'd7);
        idle_read(5'd7, 5'd9);

        // Writes to r0 are discarded.
        applyStimulus(0, 1, 0, 0, 5'd0, 32'hFFFFFFFF, 32'd0, 32'd0, 5'd0, 5'd0);
        idle_read(5'd0, 5'd7);

        // Sequence r1..r31 = index*3, then r1 = 0x55 from a fresh reset.
        applyStimulus(1, 0, 0, 0, 5'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0);
        for (int i = 1; i < 32; i++) begin
            applyStimulus(0, 1, 0, 0, 5'(i), 32'(i * 3), 32'd0, 32'd0,
                          5'(i), 5'(i - 1));
        end
        applyStimulus(0, 1, 1, 0, 5'd1, 32'd0, 32'h55, 32'd0, 5'd1, 5'd2);
        idle_read(5'd1, 5'd2);
        idle_read(5'd31, 5'd30);

        // Back-to-back writes to one register: last one wins.
        applyStimulus(0, 1, 0, 0, 5'd12, 32'h111, 32'd0, 32'd0, 5'd12, 5'd13);
        applyStimulus(0, 1, 0, 0, 5'd12, 32'h222, 32'd0, 32'd0, 5'd12, 5'd13);
        idle_read(5'd12, 5'd1);

        // reg_write low with random everything else changes nothing.
        for (int i = 0; i < 20; i++) begin
            applyStimulus(0, 0, 1'($urandom), 1'($urandom), 5'($urandom),
                          $urandom, $urandom, $urandom,
                          5'($urandom), 5'($urandom));
        end

        // Fully random traffic, with a rare reset.
        for (int i = 0; i < 300; i++) begin
            applyStimulus(($urandom_range(0, 49) == 0), 1'($urandom),
                          1'($urandom), 1'($urandom), 5'($urandom),
                          $urandom, $urandom, $urandom,
                          5'($urandom), 5'($urandom));
        end

        // Counter wrap from 0xFFFFFFFF.
        deposit_max = 1'b1;
        applyStimulus(0, 1, 0, 0, 5'd3, 32'h3333, 32'd0, 32'd0, 5'd3, 5'd0);
        idle_read(5'd3, 5'd0);
        idle_read(5'd3, 5'd4);

        @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
